// File: rtl/pucch_sym_mapper.sv
// Streaming pi/2-BPSK / QPSK symbol mapper for PUCCH formats 3/4.
// Serial coded bits in, framed complex symbols out, with ready/valid on both sides.
module pucch_sym_mapper #(
  parameter int W     = 16,
  parameter int AMP   = 23170,
  parameter int IDX_W = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_mode,
  input  logic                 i_bit,
  input  logic                 i_bit_valid,
  input  logic                 i_sop,
  input  logic                 i_eop,
  output logic                 o_bit_ready,
  output logic signed [W-1:0]  o_re,
  output logic signed [W-1:0]  o_im,
  output logic [IDX_W-1:0]     o_sym_idx,
  output logic                 o_last,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_pad_err
);

  typedef enum logic [1:0] {IDLE, ACTIVE, HALF} state_t;

  localparam logic signed [W-1:0] POS = W'(AMP);
  localparam logic signed [W-1:0] NEG = W'(-AMP);

  // A coded bit of 1 maps to the negative constellation level.
  function automatic logic signed [W-1:0] level(input logic neg);
    return neg ? NEG : POS;
  endfunction

  state_t             state_q;
  logic               mode_q;
  logic               b0_q;
  logic [IDX_W-1:0]   idx_q;

  logic               bit_acc;
  logic               mode_eff;
  logic [IDX_W-1:0]   idx_eff;
  logic               in_cw;
  logic               emit_p0;
  logic               pad_p0;
  logic               hold_p0;
  logic signed [W-1:0] re_p0;
  logic signed [W-1:0] im_p0;
  state_t             state_d;

  assign o_bit_ready = ~o_valid | i_ready;
  assign bit_acc     = i_bit_valid & o_bit_ready;

  // Stage p0: decode the accepted bit against the current codeword context.
  // An accepted sop overrides the stored mode/index so a restart takes effect
  // on the very bit that carries it.
  always_comb begin
    mode_eff = i_sop ? i_mode : mode_q;
    idx_eff  = i_sop ? '0 : idx_q;
    in_cw    = (state_q != IDLE) | i_sop;
    emit_p0  = 1'b0;
    pad_p0   = 1'b0;
    hold_p0  = 1'b0;
    re_p0    = POS;
    im_p0    = POS;
    state_d  = state_q;
    if (bit_acc && in_cw) begin
      if (!mode_eff) begin
        emit_p0 = 1'b1;
        re_p0   = level(i_bit ^ idx_eff[0]);
        im_p0   = level(i_bit);
        state_d = i_eop ? IDLE : ACTIVE;
      end else if (state_q == HALF && !i_sop) begin
        emit_p0 = 1'b1;
        re_p0   = level(b0_q);
        im_p0   = level(i_bit);
        state_d = i_eop ? IDLE : ACTIVE;
      end else if (i_eop) begin
        // Odd-length QPSK codeword: pad b1 with 0 and flag it.
        emit_p0 = 1'b1;
        pad_p0  = 1'b1;
        re_p0   = level(i_bit);
        im_p0   = POS;
        state_d = IDLE;
      end else begin
        hold_p0 = 1'b1;
        state_d = HALF;
      end
    end
  end

  // Stage p1: registered symbol output and codeword bookkeeping.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      mode_q    <= 1'b0;
      b0_q      <= 1'b0;
      idx_q     <= '0;
      o_valid   <= 1'b0;
      o_re      <= '0;
      o_im      <= '0;
      o_sym_idx <= '0;
      o_last    <= 1'b0;
      o_pad_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      o_pad_err <= pad_p0;
      if (bit_acc && i_sop)
        mode_q <= i_mode;
      if (hold_p0)
        b0_q <= i_bit;
      if (emit_p0)
        idx_q <= idx_eff + IDX_W'(1);
      else if (bit_acc && i_sop)
        idx_q <= '0;
      if (emit_p0) begin
        o_valid   <= 1'b1;
        o_re      <= re_p0;
        o_im      <= im_p0;
        o_sym_idx <= idx_eff;
        o_last    <= i_eop;
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pucch_sym_mapper.sv
// Directed and randomized-handshake bench for pucch_sym_mapper.
// A second instance with a 4-bit index exercises counter wrap on shared stimulus.
module tb_pucch_sym_mapper;

  logic i_clk = 1'b0;
  logic i_rst_n, i_mode, i_bit, i_bit_valid, i_sop, i_eop, i_ready;
  logic o_bit_ready, o_last, o_valid, o_pad_err;
  logic signed [15:0] o_re, o_im;
  logic [15:0] o_sym_idx;
  logic rdy4, last4, valid4, pad4;
  logic signed [15:0] re4, im4;
  logic [3:0] idx4;

  localparam logic signed [15:0] PA = 16'sd23170;
  localparam logic signed [15:0] NA = -16'sd23170;

  int vecs = 0;
  int errs = 0;

  always #5 i_clk = ~i_clk;

  pucch_sym_mapper #(.W(16), .AMP(23170), .IDX_W(16)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_mode(i_mode), .i_bit(i_bit),
    .i_bit_valid(i_bit_valid), .i_sop(i_sop), .i_eop(i_eop),
    .o_bit_ready(o_bit_ready), .o_re(o_re), .o_im(o_im), .o_sym_idx(o_sym_idx),
    .o_last(o_last), .o_valid(o_valid), .i_ready(i_ready), .o_pad_err(o_pad_err)
  );

  pucch_sym_mapper #(.W(16), .AMP(23170), .IDX_W(4)) dut4 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_mode(i_mode), .i_bit(i_bit),
    .i_bit_valid(i_bit_valid), .i_sop(i_sop), .i_eop(i_eop),
    .o_bit_ready(rdy4), .o_re(re4), .o_im(im4), .o_sym_idx(idx4),
    .o_last(last4), .o_valid(valid4), .i_ready(i_ready), .o_pad_err(pad4)
  );

  task automatic drive(input logic b, input logic sop, input logic eop, input logic mode);
    i_bit = b; i_sop = sop; i_eop = eop; i_mode = mode; i_bit_valid = 1'b1;
    @(posedge i_clk); #1;
    i_bit_valid = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
  endtask

  task automatic test_reset;
    i_rst_n = 1'b0; i_mode = 1'b0; i_bit = 1'b0; i_bit_valid = 1'b0;
    i_sop = 1'b0; i_eop = 1'b0; i_ready = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    vecs++;
    if ({o_valid, o_re, o_im, o_sym_idx, o_last, o_pad_err, o_bit_ready} !== {1'b0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1}) begin
      errs++;
      $display("FAIL reset: got v=%b re=%0d im=%0d idx=%0d last=%b pad=%b rdy=%b, want 0/0/0/0/0/0/1",
               o_valid, o_re, o_im, o_sym_idx, o_last, o_pad_err, o_bit_ready);
    end
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
  endtask

  task automatic test_bpsk;
    logic [3:0] bits;
    logic signed [15:0] er [4];
    logic signed [15:0] ei [4];
    bits = 4'b1100;
    er = '{PA, NA, NA, PA};
    ei = '{PA, PA, NA, NA};
    for (int i = 0; i < 4; i++) begin
      drive(bits[i], i == 0, i == 3, 1'b0);
      vecs++;
      if ({o_valid, o_re, o_im, o_sym_idx, o_last, o_pad_err} !== {1'b1, er[i], ei[i], 16'(i), 1'(i == 3), 1'b0}) begin
        errs++;
        $display("FAIL bpsk sym%0d: got v=%b (%0d,%0d) idx=%0d last=%b pad=%b, want (%0d,%0d) idx=%0d last=%b",
                 i, o_valid, o_re, o_im, o_sym_idx, o_last, o_pad_err, er[i], ei[i], i, i == 3);
      end
    end
  endtask

  task automatic test_qpsk;
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    vecs++;
    if (o_valid !== 1'b0) begin
      errs++; $display("FAIL qpsk_b0_hold: got valid=%b, want 0", o_valid);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    vecs++;
    if ({o_valid, o_re, o_im, o_sym_idx, o_last, o_pad_err} !== {1'b1, PA, NA, 16'd0, 1'b0, 1'b0}) begin
      errs++;
      $display("FAIL qpsk sym0: got v=%b (%0d,%0d) idx=%0d last=%b pad=%b, want (23170,-23170) idx=0 last=0 pad=0",
               o_valid, o_re, o_im, o_sym_idx, o_last, o_pad_err);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    vecs++;
    if ({o_valid, o_re, o_im, o_sym_idx, o_last, o_pad_err} !== {1'b1, NA, PA, 16'd1, 1'b1, 1'b0}) begin
      errs++;
      $display("FAIL qpsk sym1: got v=%b (%0d,%0d) idx=%0d last=%b pad=%b, want (-23170,23170) idx=1 last=1 pad=0",
               o_valid, o_re, o_im, o_sym_idx, o_last, o_pad_err);
    end
  endtask

  task automatic test_qpsk_pad;
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    vecs++;
    if ({o_valid, o_re, o_im, o_sym_idx, o_last, o_pad_err} !== {1'b1, NA, NA, 16'd0, 1'b0, 1'b0}) begin
      errs++;
      $display("FAIL pad sym0: got v=%b (%0d,%0d) idx=%0d last=%b pad=%b, want (-23170,-23170) idx=0",
               o_valid, o_re, o_im, o_sym_idx, o_last, o_pad_err);
    end
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    vecs++;
    if ({o_valid, o_re, o_im, o_sym_idx, o_last, o_pad_err} !== {1'b1, NA, PA, 16'd1, 1'b1, 1'b1}) begin
      errs++;
      $display("FAIL pad sym1: got v=%b (%0d,%0d) idx=%0d last=%b pad=%b, want (-23170,23170) idx=1 last=1 pad=1",
               o_valid, o_re, o_im, o_sym_idx, o_last, o_pad_err);
    end
    @(posedge i_clk); #1;
    vecs++;
    if ({o_valid, o_pad_err} !== 2'b00) begin
      errs++; $display("FAIL pad_pulse_width: got valid=%b pad=%b, want 0 0", o_valid, o_pad_err);
    end
  endtask

  task automatic test_single_and_restart;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    vecs++;
    if (o_valid !== 1'b0) begin
      errs++; $display("FAIL idle_drop: got valid=%b, want 0", o_valid);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    vecs++;
    if ({o_valid, o_re, o_im, o_sym_idx, o_last, o_pad_err} !== {1'b1, NA, NA, 16'd0, 1'b1, 1'b0}) begin
      errs++;
      $display("FAIL single_bpsk: got v=%b (%0d,%0d) idx=%0d last=%b pad=%b, want (-23170,-23170) idx=0 last=1 pad=0",
               o_valid, o_re, o_im, o_sym_idx, o_last, o_pad_err);
    end
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    vecs++;
    if ({o_valid, o_re, o_im, o_sym_idx, o_last, o_pad_err} !== {1'b1, PA, PA, 16'd0, 1'b1, 1'b1}) begin
      errs++;
      $display("FAIL single_qpsk: got v=%b (%0d,%0d) idx=%0d last=%b pad=%b, want (23170,23170) idx=0 last=1 pad=1",
               o_valid, o_re, o_im, o_sym_idx, o_last, o_pad_err);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    vecs++;
    if ({o_valid, o_pad_err} !== 2'b00) begin
      errs++; $display("FAIL restart_no_sym: got valid=%b pad=%b, want 0 0", o_valid, o_pad_err);
    end
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    vecs++;
    if ({o_valid, o_re, o_im, o_sym_idx, o_last, o_pad_err} !== {1'b1, PA, NA, 16'd0, 1'b1, 1'b0}) begin
      errs++;
      $display("FAIL restart_sym: got v=%b (%0d,%0d) idx=%0d last=%b pad=%b, want (23170,-23170) idx=0 last=1 pad=0",
               o_valid, o_re, o_im, o_sym_idx, o_last, o_pad_err);
    end
  endtask

  task automatic test_idx_wrap;
    for (int i = 0; i < 18; i++) begin
      drive(1'b0, i == 0, i == 17, 1'b0);
      vecs++;
      if ({valid4, re4, im4, idx4, last4} !== {1'b1, (i % 2 == 1) ? NA : PA, PA, 4'(i % 16), 1'(i == 17)}) begin
        errs++;
        $display("FAIL wrap sym%0d: got v=%b (%0d,%0d) idx=%0d last=%b, want idx=%0d last=%b",
                 i, valid4, re4, im4, idx4, last4, i % 16, i == 17);
      end
    end
  endtask

  task automatic test_reset_in_half;
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    i_rst_n = 1'b0;
    @(posedge i_clk); #1;
    vecs++;
    if ({o_valid, o_re, o_im, o_sym_idx, o_last, o_pad_err} !== {1'b0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0}) begin
      errs++;
      $display("FAIL reset_half: got v=%b (%0d,%0d) idx=%0d last=%b pad=%b, want all 0",
               o_valid, o_re, o_im, o_sym_idx, o_last, o_pad_err);
    end
    i_rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    vecs++;
    if ({o_valid, o_pad_err} !== 2'b00) begin
      errs++; $display("FAIL reset_idle_drop: got valid=%b pad=%b, want 0 0", o_valid, o_pad_err);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    vecs++;
    if ({o_valid, o_re, o_im, o_sym_idx, o_last, o_pad_err} !== {1'b1, PA, PA, 16'd0, 1'b1, 1'b0}) begin
      errs++;
      $display("FAIL reset_fresh: got v=%b (%0d,%0d) idx=%0d last=%b pad=%b, want (23170,23170) idx=0 last=1 pad=0",
               o_valid, o_re, o_im, o_sym_idx, o_last, o_pad_err);
    end
  endtask

  task automatic test_back_to_back;
    localparam int N = 10000;
    logic [48:0] expq [$];
    logic [48:0] cur, held, exp_sym;
    logic stalled;
    logic [15:0] midx;
    int n_acc, cyc;
    n_acc = 0; cyc = 0; midx = '0; stalled = 1'b0; held = '0;
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    while ((n_acc < N || expq.size() > 0) && cyc < 60000) begin
      i_bit_valid = (n_acc < N) && ((cyc >= 195 && cyc < 205) || $urandom_range(0, 3) != 0);
      i_bit  = 1'($urandom_range(0, 1));
      i_sop  = (n_acc == 0);
      i_eop  = (n_acc == N - 1);
      i_mode = 1'b0;
      i_ready = (cyc >= 200 && cyc < 203) ? 1'b0 : ($urandom_range(0, 3) != 0);
      @(negedge i_clk);
      cur = {o_re, o_im, o_sym_idx, o_last};
      if (stalled) begin
        vecs++;
        if (!o_valid || cur !== held) begin
          errs++;
          $display("FAIL stall_hold cyc%0d: got v=%b %h, want v=1 %h", cyc, o_valid, cur, held);
        end
      end
      if (o_valid && !i_ready) begin
        vecs++;
        if (o_bit_ready !== 1'b0) begin
          errs++; $display("FAIL stall_ready cyc%0d: got %b, want 0", cyc, o_bit_ready);
        end
      end
      if (o_valid && i_ready) begin
        vecs++;
        if (expq.size() == 0) begin
          errs++; $display("FAIL stream_extra cyc%0d: got %h, want no symbol", cyc, cur);
        end else begin
          exp_sym = expq.pop_front();
          if (cur !== exp_sym) begin
            errs++; $display("FAIL stream_sym cyc%0d: got %h, want %h", cyc, cur, exp_sym);
          end
        end
      end
      if (i_bit_valid && o_bit_ready) begin
        expq.push_back({((i_bit ^ midx[0]) ? NA : PA), (i_bit ? NA : PA), midx, i_eop});
        midx++;
        n_acc++;
      end
      stalled = o_valid && !i_ready;
      held = cur;
      @(posedge i_clk); #1;
      cyc++;
    end
    vecs++;
    if (n_acc != N || expq.size() != 0) begin
      errs++;
      $display("FAIL stream_done: got %0d bits accepted, %0d symbols pending, want %0d and 0",
               n_acc, expq.size(), N);
    end
    i_bit_valid = 1'b0; i_sop = 1'b0; i_eop = 1'b0; i_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_bpsk();
    test_qpsk();
    test_qpsk_pad();
    test_single_and_restart();
    test_idx_wrap();
    test_reset_in_half();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
